// File: rtl/pt_pkg.sv
// Shared types for the projective transform family: FSM states, pipeline depth, corner record.
package pt_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DRAIN
  } state_t;

  localparam int unsigned PIPE_LAT = 4;
  localparam int unsigned CORNER_W = 16;

  typedef struct packed {
    logic [CORNER_W-1:0] x;
    logic [CORNER_W-1:0] y;
  } corner_t;

endpackage

// File: rtl/pt_out_fifo.sv
// Synchronous FIFO with occupancy count; head reads as zero while empty.
module pt_out_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     flush,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             full, push, pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!reset_n || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/projective_transform_param.sv
// Maps a 2^SRC_W_LOG2 x 2^SRC_H_LOG2 source raster into quadrilateral A-B-C-D (bilinear),
// with a 4-stage non-stalling datapath feeding a clipped, backpressured output FIFO.
module projective_transform_param
  import pt_pkg::*;
#(
  parameter int unsigned PIXEL_W    = 18,
  parameter int unsigned SRC_W_LOG2 = 9,
  parameter int unsigned SRC_H_LOG2 = 8,
  parameter int unsigned DST_XW     = 10,
  parameter int unsigned DST_YW     = 9,
  parameter int unsigned DST_W      = 640,
  parameter int unsigned DST_H      = 480,
  parameter int unsigned FIFO_DEPTH = 8
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               frame_flag,
  input  logic               corners_flag,
  input  logic [DST_XW-1:0]  a_x, b_x, c_x, d_x,
  input  logic [DST_YW-1:0]  a_y, b_y, c_y, d_y,
  input  logic               ptflag,
  input  logic [PIXEL_W-1:0] pixel,
  input  logic               pixel_flag,
  output logic               request_pixel,
  output logic [PIXEL_W-1:0] pt_pixel_write,
  output logic [DST_XW-1:0]  pt_x,
  output logic [DST_YW-1:0]  pt_y,
  output logic               pt_wr,
  input  logic               pt_ready,
  output logic               busy,
  output logic               frame_done
);

  localparam int unsigned PW = CORNER_W + SRC_W_LOG2 + SRC_H_LOG2 + 4;
  localparam int unsigned FW = PIXEL_W + DST_YW + DST_XW;
  localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;

  typedef logic signed [PW-1:0] sval_t;

  function automatic sval_t ext(input logic [CORNER_W-1:0] c);
    return sval_t'({{(PW-CORNER_W){1'b0}}, c});
  endfunction

  function automatic sval_t lerp(input sval_t p0, input sval_t p1, input sval_t t,
                                 input int unsigned sh);
    return p0 + (((p1 - p0) * t) >>> sh);
  endfunction

  state_t state, state_next;
  corner_t in_c [4];
  corner_t sh   [4];
  corner_t act  [4];

  logic                  mode;
  logic [SRC_W_LOG2-1:0] u, u1, u2;
  logic [SRC_H_LOG2-1:0] v, v1;
  logic [PIXEL_W-1:0]    pix1, pix2, pix3, pix4;
  sval_t                 lx2, ly2, rx2, ry2, lx3, ly3, px3, py3, x4, y4;
  logic [PIPE_LAT-1:0]   vld;
  logic [CW-1:0]         fifo_count;
  logic [FW-1:0]         head;
  logic                  fifo_empty, accept, last, drained, clip, push, pop, req_next;
  int unsigned           occ_next;

  assign in_c[0] = {CORNER_W'(a_x), CORNER_W'(a_y)};
  assign in_c[1] = {CORNER_W'(b_x), CORNER_W'(b_y)};
  assign in_c[2] = {CORNER_W'(c_x), CORNER_W'(c_y)};
  assign in_c[3] = {CORNER_W'(d_x), CORNER_W'(d_y)};

  assign accept  = request_pixel && pixel_flag && (state == RUN) && !frame_flag;
  assign last    = (&u) && (&v);
  assign drained = (vld == '0) && (fifo_count == '0);
  assign clip    = (x4 >= sval_t'(DST_W)) || (y4 >= sval_t'(DST_H));
  assign push    = vld[PIPE_LAT-1] && !clip;
  assign pop     = pt_wr && pt_ready;

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (frame_flag) state_next = RUN;
      RUN:     if (frame_flag) state_next = RUN;
               else if (accept && last) state_next = DRAIN;
      DRAIN:   if (frame_flag) state_next = RUN;
               else if (drained) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Occupancy after this edge; a registered request may then admit exactly one more result.
  always_comb begin
    occ_next = 0;
    if (!frame_flag)
      occ_next = 32'(fifo_count) + 32'(push) + 32'(accept)
               + 32'($countones(vld[PIPE_LAT-2:0])) - 32'(pop);
    req_next = (state_next == RUN) && (occ_next <= FIFO_DEPTH - 1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      request_pixel <= 1'b0;
      busy          <= 1'b0;
      frame_done    <= 1'b0;
      mode          <= 1'b0;
      u             <= '0;
      v             <= '0;
      vld           <= '0;
      sh            <= '{default: '0};
      act           <= '{default: '0};
    end else begin
      state         <= state_next;
      request_pixel <= req_next;
      busy          <= (state_next != IDLE);
      frame_done    <= (state == DRAIN) && (state_next == IDLE);
      if (corners_flag) sh <= in_c;
      if (frame_flag) begin
        act  <= corners_flag ? in_c : sh;
        mode <= ptflag;
        u    <= '0;
        v    <= '0;
        vld  <= '0;
      end else begin
        vld <= {vld[PIPE_LAT-2:0], accept};
        if (accept) begin
          u <= u + 1'b1;
          if (&u) v <= v + 1'b1;
        end
      end
    end
  end

  // Bypass collapses both edges onto (u,v) so later stages need no mode awareness.
  always_ff @(posedge clk) begin
    u1   <= u;
    v1   <= v;
    pix1 <= pixel;
    u2   <= u1;
    pix2 <= pix1;
    if (mode) begin
      lx2 <= lerp(ext(act[0].x), ext(act[3].x), sval_t'(v1), SRC_H_LOG2);
      ly2 <= lerp(ext(act[0].y), ext(act[3].y), sval_t'(v1), SRC_H_LOG2);
      rx2 <= lerp(ext(act[1].x), ext(act[2].x), sval_t'(v1), SRC_H_LOG2);
      ry2 <= lerp(ext(act[1].y), ext(act[2].y), sval_t'(v1), SRC_H_LOG2);
    end else begin
      lx2 <= sval_t'(DST_XW'(u1));
      rx2 <= sval_t'(DST_XW'(u1));
      ly2 <= sval_t'(DST_YW'(v1));
      ry2 <= sval_t'(DST_YW'(v1));
    end
    lx3  <= lx2;
    ly3  <= ly2;
    px3  <= (rx2 - lx2) * sval_t'(u2);
    py3  <= (ry2 - ly2) * sval_t'(u2);
    pix3 <= pix2;
    x4   <= lx3 + (px3 >>> SRC_W_LOG2);
    y4   <= ly3 + (py3 >>> SRC_W_LOG2);
    pix4 <= pix3;
  end

  pt_out_fifo #(
    .WIDTH (FW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (frame_flag),
    .wr_en   (push),
    .wr_data ({pix4, DST_YW'(y4), DST_XW'(x4)}),
    .rd_en   (pt_ready),
    .rd_data (head),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  assign pt_wr = !fifo_empty;
  assign {pt_pixel_write, pt_y, pt_x} = head;

endmodule

// File: tb/tb_projective_transform_param.sv
// Scoreboard bench for projective_transform_param on a 4x4 source raster.
module tb_projective_transform_param;

  localparam int PIXEL_W = 18;
  localparam int DST_W   = 640;
  localparam int DST_H   = 480;

  typedef struct {
    int x;
    int y;
    int p;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n, frame_flag, corners_flag, ptflag, pixel_flag, pt_ready;
  logic [9:0] a_x, b_x, c_x, d_x;
  logic [8:0] a_y, b_y, c_y, d_y;
  logic [PIXEL_W-1:0] pixel, pt_pixel_write;
  logic [9:0] pt_x;
  logic [8:0] pt_y;
  logic request_pixel, pt_wr, busy, frame_done;

  exp_t exp_q [$];
  int n_cmp = 0, n_err = 0, n_push = 0, n_pop = 0;
  int in_mx [4], in_my [4], sh_mx [4], sh_my [4], act_mx [4], act_my [4];
  bit m_mode;
  int tx [16] = '{0, 75, 150, 225, 12, 80, 149, 218, 25, 87, 150, 212, 37, 93, 149, 205};
  int ty [16] = '{0, 25, 50, 75, 50, 65, 81, 96, 100, 106, 112, 118, 150, 146, 143, 140};

  always #5 clk = ~clk;

  projective_transform_param #(
    .PIXEL_W(18), .SRC_W_LOG2(2), .SRC_H_LOG2(2), .DST_XW(10), .DST_YW(9),
    .DST_W(640), .DST_H(480), .FIFO_DEPTH(8)
  ) dut (
    .clk(clk), .reset_n(reset_n), .frame_flag(frame_flag), .corners_flag(corners_flag),
    .a_x(a_x), .b_x(b_x), .c_x(c_x), .d_x(d_x),
    .a_y(a_y), .b_y(b_y), .c_y(c_y), .d_y(d_y),
    .ptflag(ptflag), .pixel(pixel), .pixel_flag(pixel_flag), .request_pixel(request_pixel),
    .pt_pixel_write(pt_pixel_write), .pt_x(pt_x), .pt_y(pt_y), .pt_wr(pt_wr),
    .pt_ready(pt_ready), .busy(busy), .frame_done(frame_done)
  );

  task automatic chk(input string name, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, expv);
    end
  endtask

  function automatic void model(input int idx, output int x, output int y);
    int u, v, lx, ly, rx, ry;
    u = idx % 4;
    v = idx / 4;
    if (!m_mode) begin
      x = u;
      y = v;
    end else begin
      lx = act_mx[0] + (((act_mx[3] - act_mx[0]) * v) >>> 2);
      ly = act_my[0] + (((act_my[3] - act_my[0]) * v) >>> 2);
      rx = act_mx[1] + (((act_mx[2] - act_mx[1]) * v) >>> 2);
      ry = act_my[1] + (((act_my[2] - act_my[1]) * v) >>> 2);
      x  = lx + (((rx - lx) * u) >>> 2);
      y  = ly + (((ry - ly) * u) >>> 2);
    end
  endfunction

  task automatic set_corners(input int ax, ay, bx, by, cx, cy, dx, dy);
    a_x = 10'(ax); a_y = 9'(ay); b_x = 10'(bx); b_y = 9'(by);
    c_x = 10'(cx); c_y = 9'(cy); d_x = 10'(dx); d_y = 9'(dy);
    in_mx = '{ax, bx, cx, dx};
    in_my = '{ay, by, cy, dy};
  endtask

  task automatic start_frame(input bit load, input bit mode, input bit abort);
    @(negedge clk);
    frame_flag   = 1'b1;
    corners_flag = load;
    ptflag       = mode;
    if (load) begin
      sh_mx = in_mx;
      sh_my = in_my;
    end
    act_mx = sh_mx;
    act_my = sh_my;
    m_mode = mode;
    if (abort) begin
      #2;
      exp_q.delete();
      n_push = n_pop;
    end
    @(negedge clk);
    frame_flag   = 1'b0;
    corners_flag = 1'b0;
  endtask

  task automatic stream(input int first, input int last_idx, input int base, input bit use_tab);
    int idx, guard, x, y;
    idx = first;
    guard = 0;
    while (idx < last_idx && guard < 1000) begin
      @(negedge clk);
      guard++;
      pixel_flag = 1'b1;
      pixel = PIXEL_W'(base + idx);
      if (request_pixel) begin
        if (use_tab) begin
          x = tx[idx];
          y = ty[idx];
        end else model(idx, x, y);
        if (x < DST_W && y < DST_H) begin
          exp_q.push_back('{x: x, y: y, p: base + idx});
          n_push++;
        end
        idx++;
      end
    end
    chk("stream_accepts", idx, last_idx);
    @(negedge clk);
    pixel_flag = 1'b0;
  endtask

  task automatic wait_done(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 400 && !seen; i++) begin
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    chk({name, "_done_seen"}, int'(seen), 1);
    chk({name, "_busy_at_done"}, int'(busy), 0);
    chk({name, "_all_written"}, exp_q.size(), 0);
    @(negedge clk);
    chk({name, "_done_one_cycle"}, int'(frame_done), 0);
  endtask

  task automatic check_idle(input string name);
    chk({name, "_ctrl"}, int'({request_pixel, pt_wr, busy, frame_done}), 0);
    chk({name, "_x"}, int'(pt_x), 0);
    chk({name, "_y"}, int'(pt_y), 0);
    chk({name, "_pix"}, int'(pt_pixel_write), 0);
  endtask

  // Monitor: samples just after the negedge so it sees the values present at the next posedge.
  initial begin : monitor
    bit prev_stall;
    int hx, hy, hp;
    exp_t e;
    prev_stall = 1'b0;
    forever begin
      @(negedge clk);
      #1;
      if (!reset_n) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk("stall_hold_wr", int'(pt_wr), 1);
          chk("stall_hold_x", int'(pt_x), hx);
          chk("stall_hold_y", int'(pt_y), hy);
          chk("stall_hold_pix", int'(pt_pixel_write), hp);
        end
        if (pt_wr && pt_ready) begin
          n_pop++;
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL unexpected_write: got x=%0d y=%0d pix=%0d, expected no write",
                     pt_x, pt_y, pt_pixel_write);
          end else begin
            e = exp_q.pop_front();
            chk("write_x", int'(pt_x), e.x);
            chk("write_y", int'(pt_y), e.y);
            chk("write_pix", int'(pt_pixel_write), e.p);
          end
        end
        prev_stall = pt_wr && !pt_ready;
        hx = int'(pt_x);
        hy = int'(pt_y);
        hp = int'(pt_pixel_write);
      end
    end
  end

  initial begin
    reset_n = 1'b0; frame_flag = 1'b0; corners_flag = 1'b0; ptflag = 1'b0;
    pixel_flag = 1'b0; pixel = '0; pt_ready = 1'b1;
    set_corners(0, 0, 0, 0, 0, 0, 0, 0);
    sh_mx = '{0, 0, 0, 0}; sh_my = '{0, 0, 0, 0};
    act_mx = sh_mx; act_my = sh_my; m_mode = 1'b0;
    repeat (3) @(negedge clk);
    check_idle("reset");
    reset_n = 1'b1;

    // Transform frame against the hand-computed table.
    set_corners(0, 0, 300, 100, 250, 150, 50, 200);
    start_frame(1'b1, 1'b1, 1'b0);
    stream(0, 16, 100, 1'b1);
    wait_done("xform");

    // Bypass frame: raster (u,v).
    start_frame(1'b0, 1'b0, 1'b0);
    stream(0, 16, 200, 1'b0);
    wait_done("bypass");

    // Backpressure: 20-cycle stall mid-frame.
    start_frame(1'b0, 1'b1, 1'b0);
    fork
      stream(0, 16, 300, 1'b0);
      begin
        repeat (6) @(negedge clk);
        pt_ready = 1'b0;
        repeat (15) @(negedge clk);
        chk("stall_request_low", int'(request_pixel), 0);
        chk("stall_outstanding", n_push - n_pop, 8);
        repeat (5) @(negedge clk);
        pt_ready = 1'b1;
      end
    join
    wait_done("stall");

    // Clipping at x >= 640.
    set_corners(0, 0, 700, 100, 1000, 150, 50, 200);
    start_frame(1'b1, 1'b1, 1'b0);
    stream(0, 16, 400, 1'b0);
    wait_done("clip");

    // Abort after 7 accepts; restart with new corners.
    set_corners(0, 0, 300, 100, 250, 150, 50, 200);
    start_frame(1'b1, 1'b1, 1'b0);
    stream(0, 7, 500, 1'b0);
    set_corners(10, 20, 310, 30, 320, 220, 20, 210);
    start_frame(1'b1, 1'b1, 1'b1);
    stream(0, 16, 600, 1'b0);
    wait_done("abort");

    // Corner load during RUN is shadowed until the next frame.
    set_corners(0, 0, 300, 100, 250, 150, 50, 200);
    start_frame(1'b1, 1'b1, 1'b0);
    stream(0, 5, 700, 1'b0);
    @(negedge clk);
    set_corners(100, 50, 400, 60, 380, 300, 90, 280);
    corners_flag = 1'b1;
    sh_mx = in_mx;
    sh_my = in_my;
    @(negedge clk);
    corners_flag = 1'b0;
    stream(5, 16, 700, 1'b0);
    wait_done("shadow");
    start_frame(1'b0, 1'b1, 1'b0);
    stream(0, 5, 800, 1'b0);

    // Mid-frame reset, then a frame on the cleared shadow corners.
    @(negedge clk);
    reset_n = 1'b0;
    #2;
    exp_q.delete();
    n_push = n_pop;
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    check_idle("midreset");
    sh_mx = '{0, 0, 0, 0};
    sh_my = '{0, 0, 0, 0};
    start_frame(1'b0, 1'b1, 1'b0);
    stream(0, 16, 900, 1'b0);
    wait_done("post_reset");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
